// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer seconds stage.
// Holds the run-control state encoding, the default tick divider,
// BCD digit limits and the init-digit clamp helper.
package timer_pkg;

    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;
    localparam int unsigned SEC_TEN_MAX      = 5;
    localparam int unsigned DIGIT_MAX        = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Saturate a BCD digit at lim so out-of-range init values load as the maximum.
    function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] d,
                                                     input logic [DIGIT_W-1:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing the one-second time base.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   en           - count enable (high while the timer runs)
//   clr          - synchronous clear of the prescaler (wins over en)
//   tick         - one-cycle pulse while en and the count sits at TICK_DIV-1
//   last_next    - the count will be TICK_DIV-1 after the coming edge
module tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic last_next
);

    localparam int unsigned     CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next count: clear, wrap at LAST, or hold while disabled.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (en) begin
            w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign tick      = en && (r_cnt == LAST);
    // Lets the owner register a pulse that lines up with the next tick cycle.
    assign last_next = (w_cnt_nxt == LAST);

endmodule

// File: rtl/timer_sec_ctrl.sv
// Seconds stage and run-control FSM of the countdown timer.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   start_pause, clear         - one-cycle control pulses
//   sec_ten_init, sec_one_init - BCD seconds preset (clamped to 59)
//   min_ten, min_one           - current minutes from the minute counter
//   sec_ten, sec_one           - BCD seconds digits
//   min_en, min_dec            - minute counter enable / decrement pulse
//   running, done              - RUN / DONE state flags
module timer_sec_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_pause,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] sec_ten_init,
    input  logic [DIGIT_W-1:0] sec_one_init,
    input  logic [DIGIT_W-1:0] min_ten,
    input  logic [DIGIT_W-1:0] min_one,
    output logic [DIGIT_W-1:0] sec_ten,
    output logic [DIGIT_W-1:0] sec_one,
    output logic               min_en,
    output logic               min_dec,
    output logic               running,
    output logic               done
);

    localparam logic [DIGIT_W-1:0] TEN_MAX = DIGIT_W'(SEC_TEN_MAX);
    localparam logic [DIGIT_W-1:0] ONE_MAX = DIGIT_W'(DIGIT_MAX);
    localparam logic [DIGIT_W-1:0] ZERO    = DIGIT_W'(0);

    state_t             r_state, w_state_nxt;
    logic [DIGIT_W-1:0] r_sec_ten, r_sec_one;
    logic [DIGIT_W-1:0] w_sec_ten_nxt, w_sec_one_nxt;
    logic               r_min_dec, w_min_dec_nxt;
    logic [DIGIT_W-1:0] w_ten_ld, w_one_ld;
    logic               w_tick, w_last_nxt;
    logic               w_pre_en, w_pre_clr;
    logic               w_min_zero, w_sec_zero;

    assign w_ten_ld   = clamp_bcd(sec_ten_init, TEN_MAX);
    assign w_one_ld   = clamp_bcd(sec_one_init, ONE_MAX);
    assign w_min_zero = (min_ten == ZERO) && (min_one == ZERO);
    assign w_sec_zero = (r_sec_ten == ZERO) && (r_sec_one == ZERO);

    // Prescaler runs only in RUN; IDLE keeps it at zero so a start always gets a full period.
    assign w_pre_en  = (r_state == ST_RUN);
    assign w_pre_clr = clear || (r_state == ST_IDLE);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .reset     (reset),
        .en        (w_pre_en),
        .clr       (w_pre_clr),
        .tick      (w_tick),
        .last_next (w_last_nxt)
    );

    // Next state, seconds digits and minute-borrow pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_sec_ten_nxt = r_sec_ten;
        w_sec_one_nxt = r_sec_one;
        w_min_dec_nxt = 1'b0;

        if (clear) begin
            w_state_nxt   = ST_IDLE;
            w_sec_ten_nxt = w_ten_ld;
            w_sec_one_nxt = w_one_ld;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_pause) begin
                        w_state_nxt = (w_min_zero && w_sec_zero) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_tick) begin
                        if (r_sec_one != ZERO) begin
                            w_sec_one_nxt = r_sec_one - DIGIT_W'(1);
                        end else if (r_sec_ten != ZERO) begin
                            w_sec_ten_nxt = r_sec_ten - DIGIT_W'(1);
                            w_sec_one_nxt = ONE_MAX;
                        end else begin
                            // 00 with minutes left: borrow a minute (min_dec is high this cycle).
                            w_sec_ten_nxt = TEN_MAX;
                            w_sec_one_nxt = ONE_MAX;
                        end
                    end
                    if (start_pause) begin
                        w_state_nxt = ST_PAUSE;
                    end
                    if (w_tick && (w_sec_ten_nxt == ZERO) && (w_sec_one_nxt == ZERO) && w_min_zero) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (start_pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        // Registered one cycle early so the pulse covers exactly the upcoming tick cycle at 00.
        w_min_dec_nxt = !clear && (w_state_nxt == ST_RUN) && w_last_nxt &&
                        (w_sec_ten_nxt == ZERO) && (w_sec_one_nxt == ZERO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sec_ten <= w_ten_ld;
            r_sec_one <= w_one_ld;
            r_min_dec <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sec_ten <= w_sec_ten_nxt;
            r_sec_one <= w_sec_one_nxt;
            r_min_dec <= w_min_dec_nxt;
        end
    end

    assign sec_ten = r_sec_ten;
    assign sec_one = r_sec_one;
    assign running = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign min_en  = running;
    assign min_dec = r_min_dec;

endmodule

// File: tb/tb_timer_sec_ctrl.sv
// Scoreboard bench for timer_sec_ctrl with TICK_DIV = 4 and a BCD minute counter model attached.
module tb_timer_sec_ctrl;

    logic       clk;
    logic       reset;
    logic       start_pause;
    logic       clear;
    logic [3:0] sec_ten_init;
    logic [3:0] sec_one_init;
    logic [3:0] min_ten;
    logic [3:0] min_one;
    logic [3:0] sec_ten;
    logic [3:0] sec_one;
    logic       min_en;
    logic       min_dec;
    logic       running;
    logic       done;

    logic [7:0] min_init;
    logic [7:0] r_min;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic       mon_en;
    logic [7:0] prev;
    logic [7:0] w_sec;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    exp_t sec_q[$];
    int   dec_q[$];

    timer_sec_ctrl #(
        .TICK_DIV (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_pause  (start_pause),
        .clear        (clear),
        .sec_ten_init (sec_ten_init),
        .sec_one_init (sec_one_init),
        .min_ten      (min_ten),
        .min_one      (min_one),
        .sec_ten      (sec_ten),
        .sec_one      (sec_one),
        .min_en       (min_en),
        .min_dec      (min_dec),
        .running      (running),
        .done         (done)
    );

    assign w_sec   = {sec_ten, sec_one};
    assign min_ten = r_min[7:4];
    assign min_one = r_min[3:0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Minute down-counter model: reloads only on reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_min <= min_init;
        end else if (min_en && min_dec) begin
            if (r_min[3:0] == 4'd0) r_min <= {r_min[7:4] - 4'd1, 4'd9};
            else                    r_min <= r_min - 8'd1;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic exp_sec(input int c, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sec_q.push_back(e);
    endtask

    // Advance to the next falling edge and score any seconds change or min_dec pulse.
    task automatic adv();
        exp_t e;
        @(negedge clk);
        if (mon_en) begin
            if (w_sec !== prev) begin
                if (sec_q.size() == 0) begin
                    chk_val("sec_unexpected", 32'(w_sec), 32'(prev));
                end else begin
                    e = sec_q.pop_front();
                    chk_val("sec_val", 32'(w_sec), 32'(e.val));
                    chk_val("sec_cyc", 32'(cyc), 32'(e.cyc));
                end
            end
            if (min_dec) begin
                chk_val("dec_with_en", 32'(min_en), 32'd1);
                if (dec_q.size() == 0) chk_val("dec_unexpected", 32'(min_dec), 32'd0);
                else                   chk_val("dec_cyc", 32'(cyc), 32'(dec_q.pop_front()));
            end
        end
        prev = w_sec;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) adv();
    endtask

    task automatic step_to(input int c);
        while (cyc < c) adv();
    endtask

    task automatic pulse_sp();
        start_pause = 1'b1;
        adv();
        start_pause = 1'b0;
    endtask

    task automatic pulse_clr();
        clear = 1'b1;
        adv();
        clear = 1'b0;
    endtask

    initial begin
        int c0;
        int t;
        reset        = 1'b0;
        start_pause  = 1'b0;
        clear        = 1'b0;
        sec_ten_init = 4'd0;
        sec_one_init = 4'd5;
        min_init     = 8'h00;
        mon_en       = 1'b0;
        prev         = 8'h00;

        step(2);
        reset = 1'b1;
        step(1);
        chk_val("rst_sec", 32'(w_sec), 32'h05);
        chk_val("rst_min_en", 32'(min_en), 32'd0);
        chk_val("rst_min_dec", 32'(min_dec), 32'd0);
        chk_val("rst_running", 32'(running), 32'd0);
        chk_val("rst_done", 32'(done), 32'd0);
        mon_en = 1'b1;

        // Basic countdown 05 -> 00, no borrow.
        c0 = cyc;
        for (int k = 1; k <= 5; k++) exp_sec(c0 + 1 + 4 * k, bcd(5 - k));
        pulse_sp();
        chk_val("basic_running", 32'(running), 32'd1);
        step_to(c0 + 20);
        chk_val("basic_done_early", 32'(done), 32'd0);
        step(1);
        chk_val("basic_done", 32'(done), 32'd1);
        chk_val("basic_running_off", 32'(running), 32'd0);
        step(2);
        pulse_sp();
        step(5);
        chk_val("done_ignores_sp", 32'(done), 32'd1);

        // Clamp: 7/12 loads 59 on clear.
        sec_ten_init = 4'd7;
        sec_one_init = 4'd12;
        exp_sec(cyc + 1, 8'h59);
        pulse_clr();
        chk_val("clamp_idle", 32'({running, done}), 32'd0);

        // Zero start goes straight to DONE.
        sec_ten_init = 4'd0;
        sec_one_init = 4'd0;
        exp_sec(cyc + 1, 8'h00);
        pulse_clr();
        chk_val("zero_pre_done", 32'(done), 32'd0);
        pulse_sp();
        chk_val("zero_done", 32'(done), 32'd1);
        step(8);
        chk_val("zero_still_done", 32'(done), 32'd1);

        // Minute borrow from 01:00.
        mon_en   = 1'b0;
        min_init = 8'h01;
        reset    = 1'b0;
        step(1);
        reset = 1'b1;
        step(1);
        mon_en = 1'b1;
        chk_val("borrow_init", 32'({r_min, w_sec}), 32'h0100);
        c0 = cyc;
        dec_q.push_back(c0 + 4);
        exp_sec(c0 + 5, 8'h59);
        for (int s = 58; s >= 0; s--) exp_sec(c0 + 5 + 4 * (59 - s), bcd(s));
        pulse_sp();
        step_to(c0 + 4);
        chk_val("borrow_min_before", 32'(r_min), 32'h01);
        step(1);
        chk_val("borrow_min_after", 32'(r_min), 32'h00);
        step_to(c0 + 5 + 4 * 59 - 1);
        chk_val("borrow_done_early", 32'(done), 32'd0);
        step(1);
        chk_val("borrow_done", 32'(done), 32'd1);

        // Pause / resume, then clear mid-run and clear coincident with a tick.
        sec_ten_init = 4'd3;
        sec_one_init = 4'd0;
        exp_sec(cyc + 1, 8'h30);
        pulse_clr();
        c0 = cyc;
        t  = c0 + 5;
        exp_sec(t, 8'h29);
        exp_sec(t + 14, 8'h28);
        exp_sec(t + 18, 8'h27);
        exp_sec(t + 20, 8'h30);
        exp_sec(t + 27, 8'h29);
        exp_sec(t + 31, 8'h30);
        pulse_sp();
        step_to(t + 1);
        pulse_sp();
        step_to(t + 6);
        chk_val("paused", 32'({running, min_en}), 32'd0);
        step_to(t + 11);
        pulse_sp();
        chk_val("resumed", 32'(running), 32'd1);
        step_to(t + 19);
        pulse_clr();
        chk_val("clr_idle", 32'({running, min_en, done}), 32'd0);
        step_to(t + 22);
        pulse_sp();
        step_to(t + 30);
        pulse_clr();
        chk_val("clr_tick_idle", 32'(running), 32'd0);
        step(3);

        // Async reset between edges mid-run.
        sec_ten_init = 4'd4;
        sec_one_init = 4'd5;
        min_init     = 8'h00;
        exp_sec(cyc + 1, 8'h45);
        pulse_clr();
        c0 = cyc;
        exp_sec(c0 + 5, 8'h44);
        pulse_sp();
        step_to(c0 + 6);
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk_val("async_sec", 32'(w_sec), 32'h45);
        chk_val("async_flags", 32'({min_en, min_dec, running, done}), 32'd0);
        step(1);
        reset = 1'b1;
        step(2);
        chk_val("release_idle", 32'({running, done, w_sec}), 32'h045);

        chk_val("sec_q_drained", 32'(sec_q.size()), 32'd0);
        chk_val("dec_q_drained", 32'(dec_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_sec_ctrl.md
# timer_sec_ctrl

- Seconds stage and run-control FSM of the countdown timer, sitting directly upstream of the minute down-counter.
- Generates the 1 Hz time base and holds the BCD seconds digits.
- Drives the minute counter's `en` and `decrease` inputs, detects 00:00 and reports completion.
- The minute counter shares `clk` and `reset` with this block.

## Interface
Parameters:
- TICK_DIV, 100_000_000, clk cycles per second tick (sim: 4)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- start_pause  in  1  one-cycle pulse (debounced upstream); start / pause / resume
- clear  in  1  one-cycle pulse; abort to IDLE
- sec_ten_init  in  4  initial seconds tens digit (BCD)
- sec_one_init  in  4  initial seconds ones digit (BCD)
- min_ten  in  4  current minute tens from minute counter
- min_one  in  4  current minute ones from minute counter
- sec_ten  out  4  seconds tens digit
- sec_one  out  4  seconds ones digit
- min_en  out  1  enable to minute counter
- min_dec  out  1  one-cycle decrement pulse to minute counter
- running  out  1  high in RUN
- done  out  1  high in DONE

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset values:
  - state IDLE; prescaler 0.
  - sec_ten and sec_one take the clamped init digits.
  - min_en, min_dec, running, done are 0.
- Init clamp, applied on every load: tens > 5 loads 5; ones > 9 loads 9.
- IDLE:
  - Seconds are held.
  - start_pause with min and sec all zero -> DONE.
  - Otherwise start_pause -> RUN with the prescaler cleared.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler == TICK_DIV-1) and state RUN.
- On tick:
  - sec_one != 0: sec_one decrements.
  - Else if sec_ten != 0: sec_ten decrements, sec_one = 9.
  - Else (sec 00, minutes nonzero by construction): sec = 59 and min_dec = 1 for that cycle.
  - If the new sec is 00 and min_ten/min_one are 00: -> DONE.
- RUN + start_pause -> PAUSE. The prescaler holds its value and is not cleared.
- PAUSE + start_pause -> RUN. Counting resumes from the held prescaler value.
- DONE:
  - sec stays 00, done = 1.
  - start_pause is ignored.
- clear in any state:
  - -> IDLE; seconds reload the clamped init digits.
  - Prescaler is cleared; min_dec is forced low.
  - The minute counter is not reloaded; only `reset` reloads minutes.
- Priority: reset > clear > tick/start_pause.
- Simultaneous tick and start_pause in RUN: the tick's decrement and any min_dec still happen, and the state goes to PAUSE. If the tick also reaches 00:00, DONE wins.
- Outputs:
  - min_en = running.
  - min_dec is only ever asserted with min_en = 1, so the minute counter never borrows below 00.

## Timing
- All state, digits, prescaler and min_dec are registered. min_en, running and done decode from registered state.
- Tick-to-digit latency: seconds digits change on the edge that ends the tick cycle.
- Minutes change on the same edge as seconds go 00 -> 59. min_dec is high for exactly the one cycle before that edge.
- Tick period in RUN is exactly TICK_DIV cycles. Time spent in PAUSE does not count.
- First tick after IDLE -> RUN comes TICK_DIV cycles after the start_pause edge.
- DONE is entered on the same edge that writes sec = 00; done is high from the next cycle.
- Reset deassertion mid-run returns to IDLE with init values. There are no partial-cycle pulses on min_dec.

## Structure
- Package `timer_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the default TICK_DIV constant;
  - BCD limit constants (SEC_TEN_MAX = 5, DIGIT_MAX = 9).
- Sub-module `tick_gen` is the prescaler:
  - parameter TICK_DIV;
  - inputs clk, reset, en, clr; output tick (one cycle).
  - Width = $clog2(TICK_DIV).
- FSM and seconds BCD logic live in `timer_sec_ctrl`.

## Test plan
All scenarios use TICK_DIV = 4.
- Basic countdown:
  - Init sec 05, min 00; start_pause.
  - Expect sec 04 after 4 cycles, then 03, 02, 01, 00.
  - done = 1 from the cycle after 00 is written; min_dec never asserted.
- Minute borrow:
  - Init sec 00, min 01 (minute counter attached); start_pause.
  - First tick: min_dec high one cycle, then sec 59 and min 00 on the same edge.
  - Sixty ticks later, sec 00 and done = 1.
- Pause/resume:
  - start_pause 2 cycles after a tick; pause 10 cycles; resume.
  - Next tick arrives 2 cycles after resume, with sec frozen during the pause.
- Zero start and clamp:
  - Init sec 00, min 00; start_pause -> DONE directly, no min_dec.
  - Separately, init sec_ten = 7, sec_one = 12 loads 59.
- Clear mid-run:
  - Init 30; after 3 ticks (sec 27) pulse clear.
  - Expect IDLE, sec 30, min_en 0, prescaler 0.
  - clear coincident with a tick also gives sec 30 and no min_dec.
- Async reset mid-run:
  - reset low between clock edges: all outputs take reset values immediately.
  - Release: IDLE with init digits.
